// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter slice.
//   arb_state_t  : arbiter FSM states (ST_IDLE, ST_SEND)
//   NUM_REQ_MAX  : largest supported requester count
//   TMR_W        : width of the packet watchdog timer
//   IDX_W        : width of a requester index (covers NUM_REQ_MAX)
//   rr_next()    : wrap-around index helper for round-robin search
package uart_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_t;

  localparam int unsigned NUM_REQ_MAX = 8;
  localparam int unsigned TMR_W       = 16;
  localparam int unsigned IDX_W       = $clog2(NUM_REQ_MAX);

  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input int unsigned k,
                                          input int unsigned n);
    return (ptr + k) % n;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   i_req    : request vector
//   i_rr_ptr : index served last; search starts at i_rr_ptr+1 with wrap
//   o_valid  : at least one request present
//   o_idx    : index of the winning request
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    // Offset k=NUM_REQ wraps back to i_rr_ptr itself, so the last winner is
    // only chosen again when nobody else is asking.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!o_valid && i_req[j] && (j == rr_next(32'(i_rr_ptr), k, NUM_REQ))) begin
          o_valid = 1'b1;
          o_idx   = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter for the UART TX FIFO push port.
// A requester owns the port from grant until it pushes a byte flagged last.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to release an owner that stays
// idle for TIMEOUT cycles (timeout_err pulses); otherwise timeout_err is 0.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   req/req_data/req_last : per-requester byte valid, byte ([8*i+:8]), last flag
//   ack             : per-requester byte accepted (combinational)
//   grant           : registered one-hot owner
//   busy            : packet in progress
//   timeout_err     : one-cycle watchdog release pulse
//   tx_full         : FIFO full back-pressure
//   tx_push/tx_push_data : push strobe and byte to the FIFO (combinational)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 tx_full,
  output logic                 tx_push,
  output logic [7:0]           tx_push_data
);

  if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX || TIMEOUT < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported NUM_REQ/TIMEOUT");
  end

  arb_state_t         r_state, w_state_n;
  logic [NUM_REQ-1:0] r_grant, w_grant_n;
  logic [IDX_W-1:0]   r_g_idx, w_g_idx_n;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_n;

  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_own_req, w_own_last, w_xfer;
  logic [7:0]         w_own_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
  logic [TMR_W-1:0] r_timer, w_timer_n;
  logic             r_timeout_err, w_tmo_n;
`endif

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx)
  );

  // Owner signal select by index compare keeps the mux width-clean for any NUM_REQ.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_last = 1'b0;
    w_own_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_g_idx == IDX_W'(i)) begin
        w_own_req  = req[i];
        w_own_last = req_last[i];
        w_own_data = req_data[8*i +: 8];
      end
    end
  end

  assign w_xfer       = (r_state == ST_SEND) && w_own_req && !tx_full;
  assign tx_push      = w_xfer;
  assign tx_push_data = w_xfer ? w_own_data : '0;
  assign ack          = w_xfer ? r_grant : '0;
  assign grant        = r_grant;
  assign busy         = (r_state == ST_SEND);
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err  = r_timeout_err;
`else
  assign timeout_err  = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_g_idx_n = r_g_idx;
    w_rr_n    = r_rr_ptr;
`ifdef UART_ARB_TIMEOUT_EN
    w_timer_n = r_timer;
    w_tmo_n   = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant_n = NUM_REQ'(1) << w_pick_idx;
          w_g_idx_n = w_pick_idx;
          w_rr_n    = w_pick_idx;
          w_state_n = ST_SEND;
`ifdef UART_ARB_TIMEOUT_EN
          w_timer_n = '0;
`endif
        end
      end
      ST_SEND: begin
        if (w_xfer && w_own_last) begin
          w_state_n = ST_IDLE;
          w_grant_n = '0;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Only an absent owner request ages the timer; tx_full stalls hold it.
        if (w_xfer) begin
          w_timer_n = '0;
        end else if (!w_own_req) begin
          if (r_timer == TMO_LAST) begin
            w_tmo_n   = 1'b1;
            w_state_n = ST_IDLE;
            w_grant_n = '0;
            w_timer_n = '0;
          end else begin
            w_timer_n = r_timer + TMR_W'(1);
          end
        end
`endif
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_g_idx  <= '0;
      r_rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state  <= w_state_n;
      r_grant  <= w_grant_n;
      r_g_idx  <= w_g_idx_n;
      r_rr_ptr <= w_rr_n;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timer       <= w_timer_n;
      r_timeout_err <= w_tmo_n;
    end
  end
`endif

endmodule
